// File: rtl/generic_sram_pkg.sv
// Shared helpers for the byte-enable SRAM family: byte-lane merge and full-mask detection.
// Helpers work on the widest supported word; callers zero-extend and take the low bits.
package generic_sram_pkg;

  localparam int unsigned BYTE_BITS     = 8;
  localparam int unsigned MAX_BE_BITS   = 64;
  localparam int unsigned MAX_DATA_BITS = MAX_BE_BITS * BYTE_BITS;

  typedef logic [MAX_BE_BITS-1:0]   be_max_t;
  typedef logic [MAX_DATA_BITS-1:0] word_max_t;

  // Each enabled lane takes the new byte, the others keep the old one.
  function automatic word_max_t byte_merge(input be_max_t be, input word_max_t new_word,
                                           input word_max_t old_word);
    word_max_t merged;
    merged = old_word;
    for (int i = 0; i < int'(MAX_BE_BITS); i++) begin
      if (be[i]) merged[i*BYTE_BITS +: BYTE_BITS] = new_word[i*BYTE_BITS +: BYTE_BITS];
    end
    return merged;
  endfunction

  function automatic logic be_full(input be_max_t be, input int lanes);
    logic full;
    full = 1'b1;
    for (int i = 0; i < int'(MAX_BE_BITS); i++) begin
      if (i < lanes && !be[i]) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/generic_sram_1r1w.sv
// Plain word array: one synchronous read port, one write port, read-before-write on a
// same-address collision.
module generic_sram_1r1w #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data
);

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] r_rd_data;

  // NOTE: storage has no reset so it maps onto a RAM macro; contents are undefined until written.
  // NOTE: non-blocking assignments make a same-edge read return the word before the write lands.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/generic_sram_byte_en_rmw.sv
// Byte-enable SRAM responder: partial writes merged by read-modify-write one cycle later,
// with forwarding. Optional partial-write counter: GENERIC_SRAM_BYTE_EN_RMW_STATS_EN.
module generic_sram_byte_en_rmw
  import generic_sram_pkg::*;
#(
  parameter int NUM_ADDR_BITS = 32,
  parameter int NUM_DATA_BITS = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_ADDR_BITS-1:0]   addr,
  input  logic                       write_en,
  input  logic [NUM_DATA_BITS/8-1:0] byte_en,
  input  logic [NUM_DATA_BITS-1:0]   write_data,
  input  logic                       read_en,
  output logic [NUM_DATA_BITS-1:0]   read_data,
  output logic [31:0]                rmw_count
);

  localparam int NUM_BE = NUM_DATA_BITS / 8;

  typedef struct packed {
    logic                     valid;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [NUM_BE-1:0]        be;
    logic [NUM_DATA_BITS-1:0] data;
  } pend_t;

  logic [MEM_ADDR_BITS-1:0] w_mem_addr;
  logic                     w_wr_accept;
  logic                     w_rd_sample;
  logic                     w_fwd_hit;
  logic [NUM_DATA_BITS-1:0] w_dout;
  logic [NUM_DATA_BITS-1:0] w_base;
  logic [NUM_DATA_BITS-1:0] w_merged;
  word_max_t                w_merged_wide;
  logic                     w_unused_bits;

  pend_t                    r_pend;
  logic                     r_fwd_valid;
  logic [NUM_DATA_BITS-1:0] r_fwd_data;
  logic                     r_rd_q;
  logic [NUM_DATA_BITS-1:0] r_hold_q;

  // Upper address bits are ignored, so those words alias onto the array.
  assign w_mem_addr    = addr[MEM_ADDR_BITS-1:0];
  assign w_wr_accept   = write_en && (byte_en != '0);
  assign w_rd_sample   = read_en || write_en;
  assign w_base        = r_fwd_valid ? r_fwd_data : w_dout;
  assign w_merged_wide = byte_merge(be_max_t'(r_pend.be), word_max_t'(r_pend.data),
                                    word_max_t'(w_base));
  assign w_merged      = w_merged_wide[NUM_DATA_BITS-1:0];
  assign w_fwd_hit     = r_pend.valid && w_rd_sample && (r_pend.addr == w_mem_addr);
  assign w_unused_bits = ^{addr, w_merged_wide};

  // The array read at a commit edge still sees the old word; forwarding covers that gap.
  generic_sram_1r1w #(
    .ADDR_BITS (MEM_ADDR_BITS),
    .DATA_BITS (NUM_DATA_BITS)
  ) u_array (
    .clk       (clk),
    .i_rd_en   (w_rd_sample),
    .i_rd_addr (w_mem_addr),
    .o_rd_data (w_dout),
    .i_wr_en   (r_pend.valid && rstn),
    .i_wr_addr (r_pend.addr),
    .i_wr_data (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend.valid <= 1'b0;
      r_fwd_valid  <= 1'b0;
      r_rd_q       <= 1'b0;
      r_hold_q     <= '0;
    end else begin
      r_pend.valid <= w_wr_accept;
      if (w_wr_accept) begin
        r_pend.addr <= w_mem_addr;
        r_pend.be   <= byte_en;
        r_pend.data <= write_data;
      end
      r_fwd_valid <= w_fwd_hit;
      if (w_fwd_hit) r_fwd_data <= w_merged;
      r_rd_q <= read_en;
      if (r_rd_q) r_hold_q <= w_base;
    end
  end

  assign read_data = r_rd_q ? w_base : r_hold_q;

`ifdef GENERIC_SRAM_BYTE_EN_RMW_STATS_EN
  logic [31:0] r_rmw_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rmw_count <= '0;
    end else if (w_wr_accept && !be_full(be_max_t'(byte_en), NUM_BE)) begin
      r_rmw_count <= r_rmw_count + 32'd1;
    end
  end

  assign rmw_count = r_rmw_count;
`else
  assign rmw_count = '0;
`endif

endmodule

// File: doc/generic_sram_byte_en_rmw.md
# generic_sram_byte_en_rmw

Byte-enable SRAM responder that serves the `sram` end of the byte-enable SRAM port. Storage is a plain 1R1W word array with no byte-write capability. Partial-word writes are done as read-modify-write behind a one-stage write pipeline with forwarding. Clients see single-cycle read latency and never stall; the block is the default memory behind any `sram_client` master in fabric and SoC tops.

## Interface
- `NUM_ADDR_BITS`, 32: width of the client word address.
- `NUM_DATA_BITS`, 32: word width; must be a multiple of 8.
- `MEM_ADDR_BITS`, 10: array depth is 2**MEM_ADDR_BITS words. `addr` bits above this are ignored, so upper addresses alias.
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: **reset is synchronous and active-low**.
- `addr` in NUM_ADDR_BITS: word address, shared by read and write.
- `write_en` in 1: write request this cycle.
- `byte_en` in NUM_DATA_BITS/8: per-byte write mask; bit i covers `write_data[8i+7:8i]`.
- `write_data` in NUM_DATA_BITS: write word.
- `read_en` in 1: read request this cycle.
- `read_data` out NUM_DATA_BITS: read result.
- `rmw_count` out 32: number of partial writes accepted (see Configuration).

## Operation
- Every accepted write (`write_en`=1, `byte_en`≠0) loads the pending register: `pend_valid`, `pend_addr`, `pend_be`, `pend_wdata`.
- The pending write commits to the array at the next edge. All writes are delayed one cycle, so the array needs only one write port.
- `write_en`=1 with `byte_en`=0 is a no-op.
- Any write, and any read, drives the array read port with `addr`. `addr` is shared, so a simultaneous read and write cannot conflict on the read port.
- **Base word:** in the cycle after a sample, `base = fwd_valid ? fwd_data : array_dout`.
- **Forwarding:** at each edge where a pending commit address equals the address sampled by the read port, set `fwd_valid`=1 and `fwd_data` = the committed merged word. Otherwise `fwd_valid`=0.
- **Merge:** the committed word is `pend_be` selecting bytes of `pend_wdata`, remaining bytes from `base`. For `pend_be` all-ones, `base` is unused.
- **Back-to-back writes to the same address:** these chain correctly through `fwd_data`.
- **Read semantics:** a read sampled at edge E returns a value that includes every write accepted before E. It excludes a write accepted at E, so read and write in the same cycle return the old word.
- **Write-after-write, no gap:** the later write wins per byte.
- **`read_data` output:** `read_data = rd_q ? base : hold_q`. `rd_q` registers `read_en`. `hold_q` captures `base` whenever `rd_q`=1. `read_data` holds its last value between reads.

## Timing
- **Reset values:** `read_data`=0, `rd_q`=0, `hold_q`=0, `pend_valid`=0, `fwd_valid`=0, `rmw_count`=0.
- **Reset mid-operation:** array contents are not reset. A pending write at an edge with `rstn`=0 is discarded (not committed).
- **Read latency:** 1 cycle. `read_en` at edge E gives valid `read_data` during cycle E+1.
- **Write visibility:** a write accepted at E is committed at E+1. It is visible to reads sampled at E+1 or later, through forwarding at E+1.
- Full throughput: one read and/or one write every cycle, with no backpressure.

## Configuration
- Macro: `GENERIC_SRAM_BYTE_EN_RMW_STATS_EN`.
- **Defined:** `rmw_count` increments by 1 at every edge accepting a write whose `byte_en` is neither 0 nor all-ones. It wraps modulo 2^32 and is cleared by reset.
- **Undefined:** `rmw_count` is tied to 0 and no counter flops exist. The port is present in both builds.

## Structure
- **Shared package `generic_sram_pkg`:**
  - function `byte_merge(be, new, old)`;
  - function `be_full(be)`;
  - the pending-write struct type (`valid`/`addr`/`be`/`data`), parameterised through localparams in the block.
- **Sub-module `generic_sram_1r1w`:**
  - word array with synchronous read and read-before-write at same-address collision;
  - no reset on storage;
  - parameters `ADDR_BITS` and `DATA_BITS`.
- All RMW, forwarding and output holding logic stays in `generic_sram_byte_en_rmw`.

## Test plan
All scenarios use NUM_DATA_BITS=32 and MEM_ADDR_BITS=10.
- **Reset:** hold `rstn`=0 for 3 cycles with random inputs → `read_data`=0 and `rmw_count`=0 throughout.
- **Full write then read:** write 0xDEADBEEF to 0x10 with be=1111, read 0x10 the next cycle → `read_data`=0xDEADBEEF one cycle later; `rmw_count` stays 0.
- **Single partial write:** then write be=0010, data 0x0000AA00 to 0x10, read in the immediately following cycle → 0xDEADAAEF; `rmw_count`=1.
- **Back-to-back partial writes:** be=0001 data 0x11, then be=1000 data 0x22000000, both to 0x10, then read → 0x22ADAA11; `rmw_count`=3.
- **Read and write same cycle:** read_en+write_en at 0x10 with 0x12345678, be=1111 → `read_data`=0x22ADAA11. The next read returns 0x12345678. `read_data` holds 0x12345678 with `read_en` low.
- **Reset and aliasing:** write 0xCAFEF00D to 0x20, assert `rstn`=0 the next cycle, then release and read 0x20 → the pre-write contents, because the pending write is dropped. Then write 0x55 to 0x401 and read 0x001 → 0x00000055 (alias).
